// File: rtl/jt49_eg_ctl.sv
// Register-side driver for the JT49 envelope generator: R11/R12 period, R13 shape,
// envelope period divider, and CPU readback of those registers.
module jt49_eg_ctl #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [3:0] ctrl,
  output logic       step,
  output logic       null_period,
  output logic       restart
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [15:0]      period;
  logic [3:0]       shape;
  logic [PRE_W-1:0] pre;
  logic [15:0]      cnt;

  logic wr11, wr12, wr13;
  logic pre_last;
  logic expire;

  assign wr11     = wr && (addr == 4'd11);
  assign wr12     = wr && (addr == 4'd12);
  assign wr13     = wr && (addr == 4'd13);
  assign pre_last = (pre == PRE_W'(PRESCALE - 1));
  // 17-bit compare so a period lowered below cnt expires at once instead of wrapping
  assign expire   = ({1'b0, cnt} + 17'd1) >= {1'b0, period};

  assign ctrl = shape;

  always_ff @(posedge clk) begin
    if (rst) begin
      period      <= '0;
      shape       <= '0;
      pre         <= '0;
      cnt         <= '0;
      step        <= 1'b0;
      restart     <= 1'b0;
      null_period <= 1'b1;
    end else begin
      restart     <= wr13;
      null_period <= (period == 16'd0);
      if (wr11) period[7:0]  <= din;
      if (wr12) period[15:8] <= din;
      if (wr13) shape        <= din[3:0];
      // A shape write restarts the envelope and wins over a coincident cen
      if (wr13) begin
        pre  <= '0;
        cnt  <= '0;
        step <= 1'b0;
      end else if (cen) begin
        if (pre_last) begin
          pre <= '0;
          if (expire) begin
            cnt  <= '0;
            step <= 1'b1;
          end else begin
            cnt  <= cnt + 16'd1;
            step <= 1'b0;
          end
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      4'd11:   dout = period[7:0];
      4'd12:   dout = period[15:8];
      4'd13:   dout = {4'h0, shape};
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_jt49_eg_ctl.sv
// Bench for jt49_eg_ctl: directed scenarios plus random traffic, every cycle
// compared against an integer reference model of the register/divider rules.
module tb_jt49_eg_ctl;

  localparam int PRESCALE = 8;

  logic       clk = 1'b0;
  logic       rst, cen, wr;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [3:0] ctrl;
  logic       step, null_period, restart;

  jt49_eg_ctl #(.PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .dout(dout), .ctrl(ctrl), .step(step), .null_period(null_period),
    .restart(restart)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = -1000;
  int prev_rise = -1000;
  int wr_cyc = 0;
  int cen_mode = 0;
  bit prev_step = 1'b0;

  int m_period, m_shape, m_pre, m_cnt;
  bit m_step, m_restart, m_null;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_dout(input int a);
    case (a)
      11:      return m_period % 256;
      12:      return m_period / 256;
      13:      return m_shape;
      default: return 0;
    endcase
  endfunction

  // One clock: choose cen, advance the model from the sampled inputs, compare outputs
  task automatic tick();
    bit w13;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = (cyc % 3 == 0);
      default: cen = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    if (rst) begin
      m_period = 0; m_shape = 0; m_pre = 0; m_cnt = 0;
      m_step = 0; m_restart = 0; m_null = 1;
    end else begin
      w13 = wr && (addr == 4'd13);
      m_null = (m_period == 0);
      m_restart = w13;
      if (w13) begin
        m_pre = 0; m_cnt = 0; m_step = 0;
      end else if (cen) begin
        if (m_pre == PRESCALE - 1) begin
          m_pre = 0;
          if (m_cnt + 1 >= m_period) begin
            m_cnt = 0; m_step = 1;
          end else begin
            m_cnt = m_cnt + 1; m_step = 0;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (wr && addr == 4'd11) m_period = (m_period / 256) * 256 + int'(din);
      if (wr && addr == 4'd12) m_period = int'(din) * 256 + (m_period % 256);
      if (w13) m_shape = int'(din) % 16;
    end
    cyc++;
    #1;
    check("ctrl", 32'(ctrl), 32'(m_shape));
    check("step", 32'(step), 32'(m_step));
    check("null_period", 32'(null_period), 32'(m_null));
    check("restart", 32'(restart), 32'(m_restart));
    check("dout", 32'(dout), 32'(model_dout(int'(addr))));
    if (step === 1'b1 && !prev_step) begin
      prev_rise = rise_cyc;
      rise_cyc = cyc;
    end
    prev_step = (step === 1'b1);
  endtask

  task automatic wr_reg(input int a, input int d);
    wr = 1'b1; addr = 4'(a); din = 8'(d);
    tick();
    wr_cyc = cyc;
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b1; addr = 4'd13; din = 8'hFF; cen = 1'b0;
    // reset held two clocks with a pending shape write
    tick(); tick();
    rst = 1'b0; wr = 1'b0; addr = 4'd11;
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_null", 32'(null_period), 1);
    check("rst_step", 32'(step), 0);
    check("rst_restart", 32'(restart), 0);
    check("rst_period_lo", 32'(dout), 0);
    tick();
    check("rst_no_restart", 32'(restart), 0);

    // period readback and ignored address
    wr_reg(11, 'h34); wr_reg(12, 'h12);
    addr = 4'd11; tick(); check("rd_r11", 32'(dout), 'h34);
    addr = 4'd12; tick(); check("rd_r12", 32'(dout), 'h12);
    wr_reg(5, 'hAA);
    addr = 4'd5;  tick(); check("rd_addr5", 32'(dout), 0);
    addr = 4'd11; tick(); check("rd_r11_kept", 32'(dout), 'h34);
    addr = 4'd12; tick(); check("rd_r12_kept", 32'(dout), 'h12);

    // period 3, cen every clock
    wr_reg(11, 3); wr_reg(12, 0); wr_reg(13, 0);
    repeat (80) tick();
    check("t3_step_gap", 32'(rise_cyc - prev_rise), 24);

    // shape write during an active count
    repeat (10) tick();
    wr_reg(13, 'h0E);
    check("t4_restart_hi", 32'(restart), 1);
    check("t4_step_clr", 32'(step), 0);
    check("t4_ctrl", 32'(ctrl), 'hE);
    tick();
    check("t4_restart_lo", 32'(restart), 0);
    repeat (29) tick();
    check("t4_rise_delay", 32'(rise_cyc - wr_cyc), 24);
    addr = 4'd13; tick(); check("t4_rd_r13", 32'(dout), 'h0E);

    // period 0 then period 1: expiry every tick
    wr_reg(11, 0); tick();
    check("t5_null_p0", 32'(null_period), 1);
    wr_reg(13, 2);
    repeat (40) tick();
    check("t5_rise_p0", 32'(rise_cyc - wr_cyc), 8);
    check("t5_step_p0", 32'(step), 1);
    wr_reg(11, 1); tick();
    check("t5_null_p1", 32'(null_period), 0);
    wr_reg(13, 2);
    repeat (40) tick();
    check("t5_rise_p1", 32'(rise_cyc - wr_cyc), 8);

    // period lowered below cnt with cen every third clock
    cen_mode = 1;
    wr_reg(12, 'h03); wr_reg(11, 'hE8); wr_reg(13, 0);
    repeat (200 * PRESCALE * 3) tick();
    wr_reg(12, 0); wr_reg(11, 'h64);
    repeat (30) tick();
    check("t6_early_expiry",
          32'((rise_cyc > wr_cyc) && (rise_cyc - wr_cyc <= 3 * PRESCALE)), 1);
    wr_reg(13, 1);
    check("t6_restart_hi", 32'(restart), 1);
    tick();
    check("t6_restart_lo", 32'(restart), 0);

    // random traffic
    cen_mode = 2;
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      wr   = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       addr = 4'd11;
        1:       addr = 4'd12;
        2:       addr = 4'd13;
        default: addr = 4'($urandom_range(0, 15));
      endcase
      if (addr == 4'd12)      din = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      else if (addr == 4'd11) din = 8'($urandom_range(0, 6));
      else                    din = 8'($urandom);
      tick();
    end
    rst = 1'b0; wr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
